// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the data-memory access controller.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam int unsigned ADDR_BASE_DEFAULT   = 1024;
    localparam int unsigned WAIT_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/dmem_access_ctrl_wait_counter.sv
// 4-bit access-latency counter with clear, enable and terminal-count flag.
module wait_counter #(
    parameter logic [3:0] TERMINAL = 4'd3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en)
            count <= count + 4'd1;
    end

    assign tc = en && (count == TERMINAL);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle data-memory access controller: stalls the pipeline while a load
// or store is outstanding and presents a one-cycle ready pulse on completion.
module dmem_access_ctrl
    import arm_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int unsigned ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Mem_R_EN,
    input  logic              Mem_W_EN,
    input  logic [31:0]       ALU_res,
    input  logic [31:0]       Val_Rm,
    output logic              ready,
    output logic [31:0]       data_mem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata
);

    state_t            state;
    logic              op_write;
    logic              req;
    logic              tc;
    logic [ADDR_W-1:0] req_addr;

    assign req      = Mem_R_EN | Mem_W_EN;
    // Truncation makes out-of-range addresses wrap modulo the array depth.
    assign req_addr = ADDR_W'((ALU_res - 32'(ADDR_BASE)) >> 2);

    always_comb begin
        ready = 1'b0;
        if (rst || state == S_IDLE)
            ready = !req;
        else if (state == S_DONE)
            ready = 1'b1;
    end

    wait_counter #(
        .TERMINAL(4'(WAIT_CYCLES - 1))
    ) u_wait_counter (
        .clk (clk),
        .rst (rst),
        .clr (state == S_IDLE),
        .en  (state == S_ACCESS),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_write  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            data_mem  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        mem_addr  <= req_addr;
                        mem_wdata <= Val_Rm;
                        op_write  <= Mem_W_EN;
                        mem_we    <= Mem_W_EN;
                        mem_re    <= !Mem_W_EN;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (tc) begin
                        if (!op_write)
                            data_mem <= mem_rdata;
                        mem_we <= 1'b0;
                        mem_re <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl with a behavioural memory array.
module tb_dmem_access_ctrl;

    localparam int unsigned WAIT = 4;
    localparam int unsigned AW   = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          Mem_R_EN, Mem_W_EN;
    logic [31:0]   ALU_res, Val_Rm;
    logic          ready;
    logic [31:0]   data_mem;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we, mem_re;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem_model [64];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .WAIT_CYCLES(WAIT),
        .ADDR_BASE(1024),
        .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .Mem_R_EN(Mem_R_EN), .Mem_W_EN(Mem_W_EN),
        .ALU_res(ALU_res), .Val_Rm(Val_Rm),
        .ready(ready), .data_mem(data_mem),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we)
            mem_model[mem_addr] <= mem_wdata;
        else if (pre_we)
            mem_model[pre_addr] <= pre_data;
    end

    assign mem_rdata = mem_re ? mem_model[mem_addr] : 32'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE and observes it until the ready pulse.
    task automatic run_req(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output logic rdy0,
                           output int we_n, output int re_n, output int done_c,
                           output logic [AW-1:0] addr_seen);
        we_n = 0; re_n = 0; done_c = 0; addr_seen = '1;
        Mem_R_EN = r; Mem_W_EN = w; ALU_res = a; Val_Rm = d;
        #1;
        rdy0 = ready;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 1) begin
                Mem_R_EN = 1'b0; Mem_W_EN = 1'b0;
                ALU_res = 32'hFFFF_FFFC; Val_Rm = 32'hBAD0_BAD0;
                #1;
            end
            if (mem_we) we_n++;
            if (mem_re) re_n++;
            if (mem_we || mem_re) addr_seen = mem_addr;
            if (ready) begin
                done_c = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; Mem_R_EN = 1'b0; Mem_W_EN = 1'b0; ALU_res = '0; Val_Rm = '0;
        pre_we = 1'b1; pre_addr = 6'd3; pre_data = 32'hDEAD_BEEF;
        step();
        pre_we = 1'b0;
        step();
        checks++;
        if (ready !== 1'b1 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b we=%b re=%b required 1 0 0", ready, mem_we, mem_re);
        end
        checks++;
        if (data_mem !== 32'h0 || mem_addr !== 6'd0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: data_mem=%h addr=%0d wdata=%h required 0 0 0", data_mem, mem_addr, mem_wdata);
        end
        Mem_R_EN = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_req: ready=%b required 0", ready);
        end
        Mem_R_EN = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_read();
        logic rdy0; int we_n, re_n, done_c; logic [AW-1:0] a;
        run_req(1'b1, 1'b0, 32'd1036, 32'h0, rdy0, we_n, re_n, done_c, a);
        checks++;
        if (rdy0 !== 1'b0) begin
            errors++; $display("FAIL read_req_ready: ready=%b required 0", rdy0);
        end
        checks++;
        if (done_c != WAIT + 1) begin
            errors++; $display("FAIL read_latency: done cycle=%0d required %0d", done_c, WAIT + 1);
        end
        checks++;
        if (re_n != WAIT || we_n != 0 || a !== 6'd3) begin
            errors++; $display("FAIL read_strobes: re=%0d we=%0d addr=%0d required 4 0 3", re_n, we_n, a);
        end
        checks++;
        if (data_mem !== 32'hDEAD_BEEF || mem_re !== 1'b0) begin
            errors++; $display("FAIL read_data: data_mem=%h re=%b required deadbeef 0", data_mem, mem_re);
        end
        step();
        checks++;
        if (ready !== 1'b1 || data_mem !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL read_idle: ready=%b data_mem=%h required 1 deadbeef", ready, data_mem);
        end
    endtask

    task automatic test_write_read();
        logic rdy0; int we_n, re_n, done_c; logic [AW-1:0] a;
        run_req(1'b0, 1'b1, 32'd1028, 32'h1234_5678, rdy0, we_n, re_n, done_c, a);
        checks++;
        if (we_n != WAIT || re_n != 0 || a !== 6'd1 || done_c != WAIT + 1) begin
            errors++; $display("FAIL write_strobes: we=%0d re=%0d addr=%0d done=%0d required 4 0 1 5", we_n, re_n, a, done_c);
        end
        checks++;
        if (data_mem !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_keeps_data: data_mem=%h required deadbeef", data_mem);
        end
        step();
        run_req(1'b1, 1'b0, 32'd1028, 32'h0, rdy0, we_n, re_n, done_c, a);
        checks++;
        if (data_mem !== 32'h1234_5678 || a !== 6'd1 || re_n != WAIT) begin
            errors++; $display("FAIL write_readback: data_mem=%h addr=%0d re=%0d required 12345678 1 4", data_mem, a, re_n);
        end
        step();
    endtask

    task automatic test_both_enables();
        logic rdy0; int we_n, re_n, done_c; logic [AW-1:0] a;
        run_req(1'b1, 1'b1, 32'd1024, 32'hA5A5_A5A5, rdy0, we_n, re_n, done_c, a);
        checks++;
        if (we_n != WAIT || re_n != 0 || a !== 6'd0) begin
            errors++; $display("FAIL both_strobes: we=%0d re=%0d addr=%0d required 4 0 0", we_n, re_n, a);
        end
        checks++;
        if (data_mem !== 32'h1234_5678 || mem_model[0] !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL both_data: data_mem=%h word0=%h required 12345678 a5a5a5a5", data_mem, mem_model[0]);
        end
        step();
    endtask

    task automatic test_wrap();
        logic rdy0; int we_n, re_n, done_c; logic [AW-1:0] a;
        run_req(1'b0, 1'b1, 32'd1280, 32'h0BAD_F00D, rdy0, we_n, re_n, done_c, a);
        checks++;
        if (a !== 6'd0 || mem_model[0] !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL wrap_high: addr=%0d word0=%h required 0 0badf00d", a, mem_model[0]);
        end
        step();
        run_req(1'b1, 1'b0, 32'd1026, 32'h0, rdy0, we_n, re_n, done_c, a);
        checks++;
        if (a !== 6'd0 || data_mem !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL wrap_low_bits: addr=%0d data_mem=%h required 0 0badf00d", a, data_mem);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        Mem_W_EN = 1'b1; ALU_res = 32'd1032; Val_Rm = 32'h7777_7777;
        step();
        Mem_W_EN = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready: ready=%b required 1", ready);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || data_mem !== 32'h0 || ready !== 1'b1 || mem_addr !== 6'd0) begin
            errors++; $display("FAIL rst_abort: we=%b data_mem=%h ready=%b addr=%0d required 0 0 1 0", mem_we, data_mem, ready, mem_addr);
        end
        step();
        checks++;
        if (mem_we !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL rst_after: we=%b ready=%b required 0 1", mem_we, ready);
        end
    endtask

    task automatic test_back_to_back();
        int n_ready = 0, last = -1, bad_gap = 0, consec = 0;
        logic prev = 1'b0;
        Mem_R_EN = 1'b1; ALU_res = 32'd1036;
        #1;
        for (int c = 0; c < 18; c++) begin
            if (c > 0) step();
            if (ready) begin
                n_ready++;
                if (prev) consec++;
                if (last >= 0 && c - last != int'(WAIT) + 2) bad_gap++;
                if (last < 0 && c != int'(WAIT) + 1) bad_gap++;
                last = c;
            end
            prev = ready;
        end
        checks++;
        if (n_ready != 3 || consec != 0 || bad_gap != 0) begin
            errors++; $display("FAIL held_request: completions=%0d consecutive=%0d bad_gaps=%0d required 3 0 0", n_ready, consec, bad_gap);
        end
        Mem_R_EN = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_both_enables();
        test_wrap();
        test_reset_mid_access();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
